// File: rtl/row_clear_engine.sv
// rtl/row_clear_engine.sv - line-clear, compaction and scoring engine for the board
//
// Captures the board on an accepted start, scans one row per cycle from the
// bottom (row ROW-1) to the top (row 0), drops full rows, packs the rest
// downward, zero-fills the top and accumulates a saturating cnt*cnt score.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request pulse, accepted only while idle
//   board_in   in   board image, sampled on the accepted start cycle
//   score_clr  in   synchronous score clear, honoured in any state
//   board_out  out  compacted board, updated once per operation
//   busy       out  operation in progress (SCAN, FILL, DONE)
//   done       out  one-cycle pulse, results valid in this cycle
//   lines      out  rows cleared by the last operation
//   any_clear  out  lines != 0
//   score      out  saturating running score
module row_clear_engine #(
  parameter int ROW     = 10,
  parameter int COL     = 8,
  parameter int SCORE_W = 16,
  localparam int LW     = $clog2(ROW + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ROW*COL-1:0]   board_in,
  input  logic                 score_clr,
  output logic [ROW*COL-1:0]   board_out,
  output logic                 busy,
  output logic                 done,
  output logic [LW-1:0]        lines,
  output logic                 any_clear,
  output logic [SCORE_W-1:0]   score
);

  localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int SQ_W = 2 * LW;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FILL, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ROW*COL-1:0]   r_work;
  logic [ROW*COL-1:0]   r_scr;
  logic [RW-1:0]        r_rd;
  // Number of rows at the top not yet written: the write target is row
  // r_wr-1, and r_wr==0 stands for the underflowed pointer (nothing to fill).
  logic [LW-1:0]        r_wr;
  logic [LW-1:0]        r_cnt;

  logic [COL-1:0]       w_row;
  logic                 w_row_full;
  logic [ROW*COL-1:0]   w_filled;
  logic [SQ_W-1:0]      w_sq;
  logic [SCORE_W-1:0]   w_inc;
  logic [SCORE_W-1:0]   w_base;
  logic [SCORE_W:0]     w_sum;
  logic [SCORE_W-1:0]   w_score_next;

  always_comb begin
    w_row = '0;
    for (int r = 0; r < ROW; r++) begin
      if (r_rd == RW'(r)) w_row = r_work[r*COL +: COL];
    end
  end

  assign w_row_full = &w_row;

  // Rows above the last written row are zeroed; the rest come from scratch.
  always_comb begin
    w_filled = '0;
    for (int r = 0; r < ROW; r++) begin
      if (LW'(r) < r_wr) w_filled[r*COL +: COL] = '0;
      else               w_filled[r*COL +: COL] = r_scr[r*COL +: COL];
    end
  end

  assign w_sq = SQ_W'(r_cnt) * SQ_W'(r_cnt);

  generate
    if (SCORE_W < SQ_W) begin : g_sat_inc
      assign w_inc = (|w_sq[SQ_W-1:SCORE_W]) ? '1 : w_sq[SCORE_W-1:0];
    end else begin : g_ext_inc
      assign w_inc = SCORE_W'(w_sq);
    end
  endgenerate

  // A coincident clear wipes the old score before the increment is added.
  assign w_base       = score_clr ? '0 : score;
  assign w_sum        = {1'b0, w_base} + {1'b0, w_inc};
  assign w_score_next = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (r_rd == '0) w_state_next = S_FILL;
      end
      S_FILL: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_scr     <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_cnt     <= '0;
      board_out <= '0;
      lines     <= '0;
      any_clear <= 1'b0;
      score     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work <= board_in;
            r_rd   <= RW'(ROW - 1);
            r_wr   <= LW'(ROW);
            r_cnt  <= '0;
          end
        end
        S_SCAN: begin
          if (w_row_full) begin
            r_cnt <= r_cnt + LW'(1);
          end else begin
            for (int r = 0; r < ROW; r++) begin
              if (r_wr == LW'(r + 1)) r_scr[r*COL +: COL] <= w_row;
            end
            r_wr <= r_wr - LW'(1);
          end
          if (r_rd != '0) r_rd <= r_rd - RW'(1);
        end
        S_FILL: begin
          board_out <= w_filled;
          lines     <= r_cnt;
          any_clear <= (r_cnt != '0);
          score     <= w_score_next;
        end
        default: ;
      endcase
      if (score_clr && (r_state != S_FILL)) score <= '0;
    end
  end

endmodule

// File: tb/tb_row_clear_engine.sv
// tb/tb_row_clear_engine.sv - directed self-checking bench for row_clear_engine
module tb_row_clear_engine;

  localparam int ROW = 10;
  localparam int COL = 8;
  localparam int LW  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ROW*COL-1:0] board_in;
  logic              score_clr;

  logic [ROW*COL-1:0] board_out, board_out8;
  logic              busy, busy8, done, done8, any_clear, any_clear8;
  logic [LW-1:0]     lines, lines8;
  logic [15:0]       score;
  logic [7:0]        score8;

  int n_checks = 0;
  int n_fail   = 0;

  row_clear_engine #(.ROW(ROW), .COL(COL), .SCORE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .board_in(board_in),
    .score_clr(score_clr), .board_out(board_out), .busy(busy), .done(done),
    .lines(lines), .any_clear(any_clear), .score(score)
  );

  row_clear_engine #(.ROW(ROW), .COL(COL), .SCORE_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .board_in(board_in),
    .score_clr(score_clr), .board_out(board_out8), .busy(busy8), .done(done8),
    .lines(lines8), .any_clear(any_clear8), .score(score8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one operation at the next negedge (cycle 0) and return at the
  // negedge of the done cycle; lat is the cycle number where done appeared.
  task automatic do_op(input logic [ROW*COL-1:0] b, output int lat);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (board_out !== '0) begin n_fail++; $display("FAIL reset_board got %h want 0", board_out); end
    n_checks++; if (lines !== '0) begin n_fail++; $display("FAIL reset_lines got %0d want 0", lines); end
    n_checks++; if (any_clear !== 1'b0) begin n_fail++; $display("FAIL reset_any got %b want 0", any_clear); end
    n_checks++; if (score !== 16'd0 || score8 !== 8'd0) begin n_fail++; $display("FAIL reset_score got %0d/%0d want 0/0", score, score8); end
  endtask

  task automatic test_no_clear;
    logic [ROW*COL-1:0] b;
    int lat;
    b = '0;
    b[9*COL +: COL] = 8'h7F;
    do_op(b, lat);
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL noclr_latency got %0d want 12", lat); end
    n_checks++; if (board_out !== b) begin n_fail++; $display("FAIL noclr_board got %h want %h", board_out, b); end
    n_checks++; if (lines !== 4'd0 || any_clear !== 1'b0) begin n_fail++; $display("FAIL noclr_lines got %0d/%b want 0/0", lines, any_clear); end
    n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL noclr_score got %0d want 0", score); end
  endtask

  task automatic test_two_rows;
    logic [ROW*COL-1:0] b, e;
    int lat;
    b = '0;
    b[9*COL +: COL] = 8'hFF;
    b[8*COL +: COL] = 8'h81;
    b[7*COL +: COL] = 8'hFF;
    b[6*COL +: COL] = 8'h3C;
    e = '0;
    e[9*COL +: COL] = 8'h81;
    e[8*COL +: COL] = 8'h3C;
    do_op(b, lat);
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL two_latency got %0d want 12", lat); end
    n_checks++; if (board_out !== e) begin n_fail++; $display("FAIL two_board got %h want %h", board_out, e); end
    n_checks++; if (lines !== 4'd2 || any_clear !== 1'b1) begin n_fail++; $display("FAIL two_lines got %0d/%b want 2/1", lines, any_clear); end
    n_checks++; if (score !== 16'd4 || score8 !== 8'd4) begin n_fail++; $display("FAIL two_score got %0d/%0d want 4/4", score, score8); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || board_out !== e) begin n_fail++; $display("FAIL two_hold got busy=%b board=%h want 0/%h", busy, board_out, e); end
  endtask

  task automatic test_all_full;
    logic [15:0] exp16 [4];
    logic [7:0]  exp8 [4];
    int lat;
    exp16[0] = 16'd100; exp16[1] = 16'd200; exp16[2] = 16'd300; exp16[3] = 16'd400;
    exp8[0]  = 8'd100;  exp8[1]  = 8'd200;  exp8[2]  = 8'd255;  exp8[3]  = 8'd255;
    @(negedge clk);
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
    n_checks++; if (score !== 16'd0 || score8 !== 8'd0) begin n_fail++; $display("FAIL full_preclear got %0d/%0d want 0/0", score, score8); end
    for (int i = 0; i < 4; i++) begin
      do_op('1, lat);
      n_checks++; if (lat !== 12 || board_out !== '0 || lines !== 4'd10) begin
        n_fail++; $display("FAIL full_op%0d got lat=%0d board=%h lines=%0d want 12/0/10", i, lat, board_out, lines); end
      n_checks++; if (score !== exp16[i] || score8 !== exp8[i]) begin
        n_fail++; $display("FAIL full_score%0d got %0d/%0d want %0d/%0d", i, score, score8, exp16[i], exp8[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [ROW*COL-1:0] b2, e2;
    int n_done;
    int first_done, second_done;
    logic [LW-1:0] lines_first;
    logic busy13;
    b2 = '0;
    b2[9*COL +: COL] = 8'hFF; b2[8*COL +: COL] = 8'h81;
    b2[7*COL +: COL] = 8'hFF; b2[6*COL +: COL] = 8'h3C;
    e2 = '0;
    e2[9*COL +: COL] = 8'h81; e2[8*COL +: COL] = 8'h3C;
    n_done = 0; first_done = -1; second_done = -1; lines_first = '1; busy13 = 1'b1;
    for (int k = 0; k <= 26; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) begin first_done = k; lines_first = lines; end
        else second_done = k;
      end
      if (k == 13) busy13 = busy;
      start    = (k == 0 || k == 5 || k == 12 || k == 13);
      board_in = (k == 5 || k == 12) ? '1 : b2;
    end
    start = 1'b0;
    n_checks++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", n_done); end
    n_checks++; if (first_done !== 12 || second_done !== 25) begin n_fail++; $display("FAIL b2b_done_cycles got %0d,%0d want 12,25", first_done, second_done); end
    n_checks++; if (lines_first !== 4'd2) begin n_fail++; $display("FAIL b2b_ignored_board got lines %0d want 2", lines_first); end
    n_checks++; if (busy13 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_fall got %b want 0", busy13); end
    n_checks++; if (board_out !== e2) begin n_fail++; $display("FAIL b2b_board got %h want %h", board_out, e2); end
  endtask

  task automatic test_reset_mid;
    logic [ROW*COL-1:0] b, e;
    int lat;
    b = '0;
    b[9*COL +: COL] = 8'hFF; b[8*COL +: COL] = 8'h81;
    b[7*COL +: COL] = 8'hFF; b[6*COL +: COL] = 8'h3C;
    e = '0;
    e[9*COL +: COL] = 8'h81; e[8*COL +: COL] = 8'h3C;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      start    = (k == 0);
      board_in = b;
      if (k == 6) rst_n = 1'b0;
    end
    start = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got busy=%b done=%b want 0/0", busy, done); end
    n_checks++; if (score !== 16'd0 || board_out !== '0) begin n_fail++; $display("FAIL rstmid_out got score=%0d board=%h want 0/0", score, board_out); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(b, lat);
    n_checks++; if (lat !== 12 || board_out !== e) begin n_fail++; $display("FAIL rstmid_rerun got lat=%0d board=%h want 12/%h", lat, board_out, e); end
    n_checks++; if (score !== 16'd4 || lines !== 4'd2) begin n_fail++; $display("FAIL rstmid_score got %0d lines %0d want 4/2", score, lines); end
  endtask

  task automatic test_score_clr;
    logic [ROW*COL-1:0] b7, b1, b3, e3;
    int lat;
    b7 = '0;
    for (int r = 3; r < ROW; r++) b7[r*COL +: COL] = 8'hFF;
    b1 = '0;
    b1[9*COL +: COL] = 8'hFF;
    b3 = '0;
    b3[9*COL +: COL] = 8'hFF; b3[8*COL +: COL] = 8'hFF;
    b3[7*COL +: COL] = 8'hFF; b3[6*COL +: COL] = 8'h12;
    e3 = '0;
    e3[9*COL +: COL] = 8'h12;
    @(negedge clk);
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
    n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL clr_idle1 got %0d want 0", score); end
    do_op(b7, lat);
    do_op(b1, lat);
    n_checks++; if (score !== 16'd50 || score8 !== 8'd50) begin n_fail++; $display("FAIL clr_setup got %0d/%0d want 50/50", score, score8); end
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 12) begin
        n_checks++; if (done !== 1'b1 || lines !== 4'd3 || board_out !== e3) begin
          n_fail++; $display("FAIL clr_fill_op got done=%b lines=%0d board=%h want 1/3/%h", done, lines, board_out, e3); end
        n_checks++; if (score !== 16'd9 || score8 !== 8'd9) begin
          n_fail++; $display("FAIL clr_fill_score got %0d/%0d want 9/9", score, score8); end
      end
      start     = (k == 0);
      board_in  = b3;
      score_clr = (k == 11);
    end
    start = 1'b0;
    score_clr = 1'b0;
    @(negedge clk);
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
    n_checks++; if (score !== 16'd0 || score8 !== 8'd0) begin n_fail++; $display("FAIL clr_idle2 got %0d/%0d want 0/0", score, score8); end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    score_clr = 1'b0;
    board_in  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_no_clear;
    test_two_rows;
    test_all_full;
    test_back_to_back;
    test_reset_mid;
    test_score_clr;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/row_clear_engine.md
# row_clear_engine

Parametrised line-clear and scoring engine for the ROW×COL Tetris board, the next-generation replacement for the fixed clear step behind the `clr_row`/`clr_over` handshake. On a `start` pulse it captures the settled board and scans it one row per cycle, bottom to top. It drops every full row, compacts the remaining rows downward, zero-fills the top, and reports the cleared-line count together with a saturating running score. It sits between the control FSM, which drives `start` and waits for `done`, and the board register in the datapath, which loads `board_out` on `done`.

## Interface
- ROW, 10, board rows; row 0 is the top, row ROW-1 the bottom.
- COL, 8, board columns; cell (r,c) is bit r*COL+c.
- SCORE_W, 16, score accumulator width.
- LW (localparam), $clog2(ROW+1), width of the line count.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; accepted only in IDLE.
- board_in  in  ROW*COL  board image; sampled on the accepted `start` cycle only.
- score_clr  in  1  synchronous score clear; honoured in any state.
- board_out  out  ROW*COL  compacted board; registered, held until the next `done`.
- busy  out  1  high from the cycle after `start` is accepted through the DONE cycle, inclusive.
- done  out  1  one-cycle pulse; `board_out`, `lines` and `score` are valid in this cycle.
- lines  out  LW  number of rows cleared by the last operation.
- any_clear  out  1  (`lines` != 0); registered alongside `lines`.
- score  out  SCORE_W  running score.

## Operation
- Reset value of every output is 0; the FSM resets to IDLE.
- FSM states and transitions:
  - IDLE: on `start`, copy `board_in` into the work register, set rd=ROW-1, wr=ROW-1, cnt=0, and go to SCAN.
  - SCAN: one row per cycle.
    - If row rd is all ones: cnt+1.
    - Otherwise: out_row[wr] <= work[rd], then wr-1.
    - Always rd-1.
    - Leave for FILL after processing rd=0.
  - FILL: in a single cycle, zero rows 0..wr. When wr has underflowed (no clears), nothing is zeroed. Then go to DONE.
  - DONE: pulse `done`, then return to IDLE.
- `board_out`, `lines`, `any_clear` and `score` update on the FILL→DONE edge only; they never show intermediate scan values.
- Score increment is cnt*cnt, computed at 2*LW bits.
  - score_next = min(score + cnt², 2^SCORE_W−1), using an adder one bit wider than SCORE_W.
  - When SCORE_W < 2*LW, the increment also saturates.
- `score_clr`:
  - Alone: score <= 0 on the next edge.
  - Coincident with the FILL→DONE update: score <= min(cnt², max). The clear applies first, then the add.
- `start` while `busy` (including the DONE cycle) is ignored; it is not queued. `board_in` changes during busy have no effect.
- Non-full rows keep their relative order. A row containing any zero bit is never cleared.
- Asynchronous reset mid-operation:
  - Returns to IDLE and zeroes all outputs, including `score`.
  - Clears the work register and the pointers.

## Timing
- `start` accepted at edge 0.
- SCAN occupies cycles 1..ROW. FILL is cycle ROW+1. DONE (`done`=1) is cycle ROW+2, which is 12 cycles for ROW=10.
- Fixed latency, independent of the number of cleared rows.
- Earliest next accepted `start` is cycle ROW+3, giving a throughput of one operation per ROW+3 cycles.
- `busy` falls in the cycle after DONE.
- Outputs hold their values between operations.

## Test plan
- No full rows (ROW=10, COL=8): row9=0x7F, all other rows 0. Start at cycle 0 → `done` at cycle 12, `board_out`==`board_in`, `lines`=0, `any_clear`=0, `score` unchanged.
- Two separated full rows: row9=0xFF, row8=0x81, row7=0xFF, row6=0x3C, rows 0..5 = 0 → `board_out` row9=0x81, row8=0x3C, rows 0..7 = 0; `lines`=2; `score` 0→4.
- All rows full → `board_out`=0, `lines`=10, `score` +=100. Repeat with SCORE_W=8 → `score` 100, 200, 255, 255 (saturates, no wrap).
- `start` pulsed at cycles 5 and 12 during an operation → both ignored, exactly one `done`. `start` at cycle 13 → accepted, `done` at cycle 25.
- `rst_n` asserted at cycle 6 mid-scan → `busy`, `done`, `score`, `board_out` are 0 immediately. After release, a fresh `start` completes correctly 12 cycles later.
- `score`=50, `score_clr` asserted on the FILL→DONE edge of a 3-line clear → `score`=9. `score_clr` alone while in IDLE → `score`=0.
